instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Parametrised successor to the fetch-stage instr_mem: word ROM, own fetch PC and a DEPTH-entry prefetch queue.
//  Streams {pc, instruction, oob} to decode with a valid/ready handshake.
//  Absorbs decode stalls; a redirect flushes the queue and restarts fetch at a new PC.
//  Sits between the PC/branch logic and decode in the fetch stage.
// PARAMETERS
//  SIZE       64                 ROM size in bytes; multiple of 4.
//  DEPTH      4                  queue entries; power of 2, >=2.
//  RESET_PC   `WORD'd0           fetch PC loaded by reset.
//  INIT_FILE  "instr_mem.mem"    $readmemh image, one `INSTR_LEN word per line, word i at byte address 4*i.
// PORTS
//  clk          in   1                    clock; rising edge.
//  rst_n        in   1                    asynchronous reset, active-low.
//  redirect     in   1                    flush the queue and refetch from redirect_pc.
//  redirect_pc  in   `WORD                new fetch PC; bits[1:0] ignored (forced 0).
//  instr_ready  in   1                    decode accepts the head entry.
//  instr_valid  out  1                    head entry valid.
//  instruction  out  `INSTR_LEN           head instruction; 0 when !instr_valid.
//  instr_pc     out  `WORD                head PC; 0 when !instr_valid.
//  instr_oob    out  1                    head PC >= SIZE; instruction reads 0.
//  count        out  $clog2(DEPTH+1)      occupied entries.
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately, no clock edge needed):
//   - fpc=RESET_PC, queue empty, halted=0.
//   - All outputs 0.
//  Fetch:
//   - Each cycle with !redirect && !halted && (count<DEPTH || (count==DEPTH && pop)), read ROM[fpc>>2].
//   - The synchronous read writes {fpc, data, oob} into the queue tail at the same edge; fpc+=4.
//   - Latency: an entry issued in cycle N is visible at the head in cycle N+1.
//   - First valid output is the cycle after rst_n rises.
//  Pop:
//   - pop = instr_valid && instr_ready; the head advances at the edge.
//   - Head outputs are stable while instr_valid && !instr_ready.
//  Simultaneous push and pop:
//   - count unchanged; allowed when full.
//   - When empty, push only (no combinational bypass).
//  Sustained throughput: 1 instr/cycle with instr_ready=1.
//  Redirect (highest priority, beats push and pop):
//   - At the edge: queue cleared (count=0), any pop that cycle is ignored.
//   - fpc = {redirect_pc[`WORD-1:2], 2'b00}; halted=0.
//   - Cycle R+1: instr_valid=0, issue at the target. Cycle R+2: target entry at the head.
//  Out of range (fpc >= SIZE):
//   - One entry is pushed with instruction=0, oob=1; then halted=1.
//   - No further pushes until redirect or reset. Draining continues normally.
//  Arithmetic:
//   - fpc wraps modulo 2^`WORD (never reached in practice).
//   - Pointers are $clog2(DEPTH) bits and wrap; count saturates by construction (never >DEPTH).
//  Reset mid-operation: all in-flight and queued entries discarded; fetch restarts at RESET_PC.
// STRUCTURE
//  fetch_pkg:
//   - typedef struct packed {logic [`WORD-1:0] pc; logic [`INSTR_LEN-1:0] instr; logic oob;} fetch_entry_t.
//   - localparam INSTR_BYTES=4.
//  Sub-module fetch_fifo #(DEPTH, fetch_entry_t):
//   - sync FIFO with push/pop/flush, full/empty/count.
//   - async active-low reset on pointers and count.
//  Top level: ROM array, fpc/halted registers, issue and redirect logic.
// TESTING (INIT_FILE: 0:ABCDEF12 4:BCDEF123 8:CDEF1234 12:DEF12345 16:EF123456 28:23456789 52:89ABCDEF
//          56:9ABCDEF1 60:ABCDEF12; SIZE=64, DEPTH=4)
//  1 Release rst_n, instr_ready=1 -> valid from cycle 1:
//    (0,ABCDEF12), (4,BCDEF123), (8,CDEF1234), one per cycle.
//  2 instr_ready=0 from reset -> count climbs 1..4 and holds; head stays (0,ABCDEF12).
//    Raise instr_ready -> pcs 0,4,8,12,16 with no gap.
//  3 redirect=1, redirect_pc=52 while full and popping -> next cycle valid=0, count=0;
//    then (52,89ABCDEF), (56,9ABCDEF1).
//  4 redirect_pc=30 -> head (28,23456789); low bits dropped.
//  5 redirect_pc=60, ready=1 -> (60,ABCDEF12, oob=0), then (64,0, oob=1), then valid=0 indefinitely.
//    A later redirect to 0 resumes (0,ABCDEF12).
//  6 Drop rst_n mid-clock-period with count=3 -> all outputs 0 before the next edge.
//    After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and widths for the fetch-stage ROM and prefetch queue.
package instr_fetch_queue_pkg;

    localparam int WORD        = 32;
    localparam int INSTR_LEN   = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [WORD-1:0]      pc;
        logic [INSTR_LEN-1:0] instr;
        logic                 oob;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO with flush; pointers and count are async-reset, storage is not.
module instr_fetch_queue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              din_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];

    // A push into a full queue is only legal when the head leaves on the same edge.
    assign do_push = push_i && !flush_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !flush_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: word ROM, fetch PC and a prefetch queue streaming {pc, instr, oob} to decode.
// The ROM contents come in as a packed image parameter, word i at bits [32*i +: 32].
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              SIZE      = 64,
    parameter int              DEPTH     = 4,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter logic [SIZE*8-1:0] ROM_IMAGE = '0,
    localparam int             CW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect,
    input  logic [WORD-1:0]      redirect_pc,
    input  logic                 instr_ready,
    output logic                 instr_valid,
    output logic [INSTR_LEN-1:0] instruction,
    output logic [WORD-1:0]      instr_pc,
    output logic                 instr_oob,
    output logic [CW-1:0]        count
);

    localparam int WORDS = SIZE / INSTR_BYTES;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [INSTR_LEN-1:0] rom [WORDS];
    logic [WORD-1:0]      fpc_q, fpc_d;
    logic                 halted_q, halted_d;
    logic [IW-1:0]        rom_idx;
    logic [INSTR_LEN-1:0] rom_word;
    logic                 fetch_oob, issue, pop;
    logic                 q_full, q_empty;
    fetch_entry_t         q_din, q_head;
    logic                 unused_rpc_lsb;

    for (genvar i = 0; i < WORDS; i++) begin : g_rom
        assign rom[i] = ROM_IMAGE[i*INSTR_LEN +: INSTR_LEN];
    end

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign fetch_oob = (fpc_q >= WORD'(SIZE));
    assign rom_idx   = fpc_q[IW+1:2];
    assign rom_word  = fetch_oob ? '0 : rom[rom_idx];

    assign pop   = instr_valid && instr_ready;
    assign issue = !redirect && !halted_q && (!q_full || pop);

    assign q_din.pc    = fpc_q;
    assign q_din.instr = rom_word;
    assign q_din.oob   = fetch_oob;

    // Redirect wins over both issue and pop; the out-of-range entry is the last one until redirect.
    always_comb begin
        fpc_d    = fpc_q;
        halted_d = halted_q;
        if (redirect) begin
            fpc_d    = {redirect_pc[WORD-1:2], 2'b00};
            halted_d = 1'b0;
        end else if (issue) begin
            fpc_d = fpc_q + WORD'(INSTR_BYTES);
            if (fetch_oob) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q    <= {RESET_PC[WORD-1:2], 2'b00};
            halted_q <= 1'b0;
        end else begin
            fpc_q    <= fpc_d;
            halted_q <= halted_d;
        end
    end

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .din_i   (q_din),
        .pop_i   (pop),
        .flush_i (redirect),
        .dout_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (count)
    );

    assign instr_valid = !q_empty;
    assign instruction = instr_valid ? q_head.instr : '0;
    assign instr_pc    = instr_valid ? q_head.pc    : '0;
    assign instr_oob   = instr_valid ? q_head.oob   : 1'b0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_queue;

    localparam int SIZE  = 64;
    localparam int DEPTH = 4;

    function automatic logic [31:0] rom_word(int i);
        case (i)
            0:       return 32'hABCDEF12;
            1:       return 32'hBCDEF123;
            2:       return 32'hCDEF1234;
            3:       return 32'hDEF12345;
            4:       return 32'hEF123456;
            7:       return 32'h23456789;
            13:      return 32'h89ABCDEF;
            14:      return 32'h9ABCDEF1;
            15:      return 32'hABCDEF12;
            default: return 32'h5A000000 | 32'(i);
        endcase
    endfunction

    function automatic logic [SIZE*8-1:0] build_img();
        logic [SIZE*8-1:0] img;
        img = '0;
        for (int i = 0; i < SIZE/4; i++) img[i*32 +: 32] = rom_word(i);
        return img;
    endfunction

    localparam logic [SIZE*8-1:0] IMG = build_img();

    logic        clk, rst_n, redir, rdy;
    logic [31:0] rpc;
    logic        instr_valid, instr_oob;
    logic [31:0] instruction, instr_pc;
    logic [2:0]  count;

    instr_fetch_queue #(
        .SIZE      (SIZE),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'd0),
        .ROM_IMAGE (IMG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redir),
        .redirect_pc (rpc),
        .instr_ready (rdy),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_oob   (instr_oob),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        oob;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_fpc;
    bit          m_halted;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fpc    = 32'd0;
        m_halted = 1'b0;
    endtask

    // One clock edge of the fetch queue, described in terms of the queue contents.
    task automatic model_edge();
        bit    popping, pushing;
        ment_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        popping = (mq.size() > 0) && rdy;
        if (redir) begin
            mq.delete();
            m_fpc    = rpc & ~32'd3;
            m_halted = 1'b0;
            return;
        end
        pushing = !m_halted && (mq.size() < DEPTH || popping);
        e.pc    = m_fpc;
        e.oob   = (m_fpc >= SIZE);
        e.instr = e.oob ? 32'd0 : rom_word(int'(m_fpc / 4));
        if (popping) void'(mq.pop_front());
        if (pushing) begin
            mq.push_back(e);
            if (e.oob) m_halted = 1'b1;
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (mq.size() > 0);
        check("valid", 64'(instr_valid), 64'(ev));
        check("instruction", 64'(instruction), ev ? 64'(mq[0].instr) : 64'd0);
        check("instr_pc", 64'(instr_pc), ev ? 64'(mq[0].pc) : 64'd0);
        check("instr_oob", 64'(instr_oob), ev ? 64'(mq[0].oob) : 64'd0);
        check("count", 64'(count), 64'(mq.size()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic pin_head(string name, logic [31:0] pc, logic [31:0] ins, logic oob);
        check({name, " dut pc"}, 64'(instr_pc), 64'(pc));
        check({name, " dut instr"}, 64'(instruction), 64'(ins));
        check({name, " dut oob"}, 64'(instr_oob), 64'(oob));
        check({name, " model pc"}, (mq.size() > 0) ? 64'(mq[0].pc) : 64'hDEAD, 64'(pc));
        check({name, " model instr"}, (mq.size() > 0) ? 64'(mq[0].instr) : 64'hDEAD, 64'(ins));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        redir = 1'b0;
        rpc   = '0;
        rdy   = 1'b0;
        model_reset();
        #1;
        check("reset valid", 64'(instr_valid), 64'd0);
        check("reset count", 64'(count), 64'd0);

        // Streaming from reset at one instruction per cycle.
        rdy = 1'b1;
        do_reset();
        step(); pin_head("s1 c1", 32'd0, 32'hABCDEF12, 1'b0);
        step(); pin_head("s1 c2", 32'd4, 32'hBCDEF123, 1'b0);
        step(); pin_head("s1 c3", 32'd8, 32'hCDEF1234, 1'b0);

        // Stall from reset: fill to DEPTH, then drain with no gap.
        rdy = 1'b0;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step();
            check("s2 fill count", 64'(count), 64'((k < DEPTH) ? k : DEPTH));
            pin_head("s2 hold", 32'd0, 32'hABCDEF12, 1'b0);
        end
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s2 drain pc", 64'(instr_pc), 64'(4 * (k + 1)));
        end
        check("s2 full while streaming", 64'(count), 64'(DEPTH));

        // Redirect while full and popping.
        redir = 1'b1; rpc = 32'd52;
        step();
        check("s3 valid after redirect", 64'(instr_valid), 64'd0);
        check("s3 count after redirect", 64'(count), 64'd0);
        redir = 1'b0;
        step(); pin_head("s3 t1", 32'd52, 32'h89ABCDEF, 1'b0);
        step(); pin_head("s3 t2", 32'd56, 32'h9ABCDEF1, 1'b0);

        // Low bits of the redirect target are dropped.
        redir = 1'b1; rpc = 32'd30;
        step();
        redir = 1'b0;
        step(); pin_head("s4", 32'd28, 32'h23456789, 1'b0);

        // Running off the end of the ROM.
        redir = 1'b1; rpc = 32'd60;
        step();
        redir = 1'b0;
        step(); pin_head("s5 last", 32'd60, 32'hABCDEF12, 1'b0);
        step(); pin_head("s5 oob", 32'd64, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s5 halted valid", 64'(instr_valid), 64'd0);
        end
        redir = 1'b1; rpc = 32'd0;
        step();
        redir = 1'b0;
        step(); pin_head("s5 resume", 32'd0, 32'hABCDEF12, 1'b0);

        // Asynchronous reset mid-period with three entries queued.
        rdy = 1'b0;
        do_reset();
        step(); step(); step();
        check("s6 count before reset", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("s6 async valid", 64'(instr_valid), 64'd0);
        check("s6 async count", 64'(count), 64'd0);
        check("s6 async pc", 64'(instr_pc), 64'd0);
        check("s6 async instr", 64'(instruction), 64'd0);
        step();
        rst_n = 1'b1;
        rdy   = 1'b1;
        step(); pin_head("s6 restart", 32'd0, 32'hABCDEF12, 1'b0);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = $urandom_range(0, 80);
            rst_n = ($urandom_range(0, 249) != 0);
            step();
        end
        rst_n = 1'b1;
        redir = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
